mux6_rr_sched: RTL and testbench

//  Round-robin scheduler that shares a 6:1 single-bit mux path among six requesters.
//  - Grants one requester at a time, holds the grant for up to MAX_BURST cycles, then rotates.
//  - Drives the binary select of the 6:1 mux and registers the muxed data bit with a valid flag.
//  - Sits in front of the 6:1/4:1/2:1 mux tree and replaces static select wiring.

---
 rtl/mux6_rr_sched_if.sv | 21 ++
 rtl/mux6_rr_sched.sv | 127 ++++++++++++
 tb/tb_mux6_rr_sched.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux6_rr_sched_if.sv
// Request/data/grant bundle between the six requesters and the round-robin mux scheduler.
interface mux6_rr_sched_if;
    logic       en;
    logic [5:0] req;
    logic [5:0] din;
    logic [5:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       y;
    logic       y_valid;

    modport master (
        output en, req, din,
        input  gnt, sel, busy, y, y_valid
    );

    modport slave (
        input  en, req, din,
        output gnt, sel, busy, y, y_valid
    );
endinterface

// File: rtl/mux6_rr_sched.sv
// Round-robin scheduler for a shared 6:1 single-bit mux: bounded-burst grants,
// binary select and a registered, valid-flagged mux output.
//
// state | meaning
// IDLE  | no grant active, gnt=0, waiting for en=1 with a pending request
// GRANT | one requester owns the mux, held for up to MAX_BURST cycles
module mux6_rr_sched #(
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    mux6_rr_sched_if.slave  bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [5:0] gnt_q, gnt_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic       busy_q;
    logic       y_q, y_valid_q;

    logic       win_found;
    logic [2:0] win_idx;
    logic [3:0] idx;
    logic       can_grant;
    logic       hold;

    // First requester at or after ptr, wrapping modulo 6
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        idx       = 4'd0;
        for (int i = 0; i < 6; i++) begin
            idx = {1'b0, ptr_q} + 4'(i);
            if (idx >= 4'd6) begin
                idx = idx - 4'd6;
            end
            if (!win_found && bus.req[idx[2:0]]) begin
                win_found = 1'b1;
                win_idx   = idx[2:0];
            end
        end
    end

    assign can_grant = bus.en && win_found;
    assign hold      = bus.req[sel_q] && (cnt_q < 4'(MAX_BURST));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                gnt_d = 6'd0;
                if (can_grant) begin
                    state_d = GRANT;
                    gnt_d   = 6'd1 << win_idx;
                    sel_d   = win_idx;
                    cnt_d   = 4'd1;
                    ptr_d   = (win_idx == 3'd5) ? 3'd0 : win_idx + 3'd1;
                end
            end
            GRANT: begin
                if (hold) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (can_grant) begin
                    gnt_d = 6'd1 << win_idx;
                    sel_d = win_idx;
                    cnt_d = 4'd1;
                    ptr_d = (win_idx == 3'd5) ? 3'd0 : win_idx + 3'd1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 6'd0;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 6'd0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 6'd0;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == GRANT);
        end
    end

    // y only updates on granted samples so it holds while y_valid is low
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            if (busy_q) begin
                y_q <= bus.din[sel_q];
            end
            y_valid_q <= busy_q;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_mux6_rr_sched.sv
// Directed bench for mux6_rr_sched: reset, lone requester, full rotation,
// early release, en gating and mid-burst reset.
module tb_mux6_rr_sched;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    mux6_rr_sched_if bus();

    mux6_rr_sched #(.MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.req = 6'h3F;
        bus.en  = 1'b1;
        bus.din = 6'h3F;
        for (int c = 0; c < 2; c++) begin
            step();
            total_cnt++;
            if (bus.gnt !== 6'd0) $display("FAIL reset_gnt cyc%0d got %b want 000000", c, bus.gnt);
            else pass_cnt++;
            total_cnt++;
            if (bus.sel !== 3'd0) $display("FAIL reset_sel cyc%0d got %0d want 0", c, bus.sel);
            else pass_cnt++;
            total_cnt++;
            if (bus.busy !== 1'b0 || bus.y_valid !== 1'b0 || bus.y !== 1'b0)
                $display("FAIL reset_flags cyc%0d busy=%b y_valid=%b y=%b want 0 0 0", c, bus.busy, bus.y_valid, bus.y);
            else pass_cnt++;
        end
        rst     = 1'b0;
        bus.req = 6'd0;
        step();
        total_cnt++;
        if (bus.gnt !== 6'd0 || bus.busy !== 1'b0) $display("FAIL idle_noreq gnt=%b busy=%b want 0", bus.gnt, bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_lone_requester();
        do_reset();
        bus.en  = 1'b1;
        bus.req = 6'b000100;
        bus.din = 6'b000100;
        for (int c = 0; c < 9; c++) begin
            step();
            total_cnt++;
            if (bus.gnt !== 6'b000100 || bus.sel !== 3'd2 || bus.busy !== 1'b1)
                $display("FAIL lone_grant cyc%0d gnt=%b sel=%0d busy=%b want 000100 2 1", c, bus.gnt, bus.sel, bus.busy);
            else pass_cnt++;
            if (c > 0) begin
                total_cnt++;
                if (bus.y !== 1'b1 || bus.y_valid !== 1'b1)
                    $display("FAIL lone_y cyc%0d y=%b y_valid=%b want 1 1", c, bus.y, bus.y_valid);
                else pass_cnt++;
            end
        end
        bus.req = 6'd0;
        step();
        total_cnt++;
        if (bus.gnt !== 6'd0 || bus.busy !== 1'b0) $display("FAIL lone_release gnt=%b busy=%b want 0 0", bus.gnt, bus.busy);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.y_valid !== 1'b0 || bus.y !== 1'b1) $display("FAIL lone_yhold y=%b y_valid=%b want 1 0", bus.y, bus.y_valid);
        else pass_cnt++;
    endtask

    task automatic test_rotation();
        logic [5:0] pat;
        logic [5:0] exp_gnt;
        logic [2:0] exp_sel;
        logic [2:0] prev_sel;
        do_reset();
        bus.en   = 1'b1;
        bus.req  = 6'h3F;
        prev_sel = 3'd0;
        for (int k = 0; k < 28; k++) begin
            pat     = 6'((k * 13 + 5) ^ (k >> 1));
            bus.din = pat;
            exp_sel = 3'(((k / 4) % 6));
            exp_gnt = 6'd1 << exp_sel;
            step();
            total_cnt++;
            if (bus.gnt !== exp_gnt || bus.sel !== exp_sel)
                $display("FAIL rot_grant k=%0d gnt=%b sel=%0d want %b %0d", k, bus.gnt, bus.sel, exp_gnt, exp_sel);
            else pass_cnt++;
            if (k > 0) begin
                total_cnt++;
                if (bus.y !== pat[prev_sel] || bus.y_valid !== 1'b1)
                    $display("FAIL rot_y k=%0d y=%b y_valid=%b want %b 1", k, bus.y, bus.y_valid, pat[prev_sel]);
                else pass_cnt++;
            end
            prev_sel = exp_sel;
        end
    endtask

    task automatic test_early_release();
        do_reset();
        bus.en  = 1'b1;
        bus.din = 6'd0;
        bus.req = 6'b010010;
        step();
        total_cnt++;
        if (bus.gnt !== 6'b000010 || bus.sel !== 3'd1) $display("FAIL early_first gnt=%b sel=%0d want 000010 1", bus.gnt, bus.sel);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.gnt !== 6'b000010) $display("FAIL early_hold gnt=%b want 000010", bus.gnt);
        else pass_cnt++;
        bus.req = 6'b010000;
        step();
        total_cnt++;
        if (bus.gnt !== 6'b010000 || bus.sel !== 3'd4 || bus.busy !== 1'b1)
            $display("FAIL early_switch gnt=%b sel=%0d busy=%b want 010000 4 1", bus.gnt, bus.sel, bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_en_gate();
        logic [5:0] exp_gnt;
        do_reset();
        bus.en  = 1'b1;
        bus.req = 6'h3F;
        bus.din = 6'b001000;
        for (int k = 0; k < 14; k++) begin
            exp_gnt = 6'd1 << (k / 4);
            step();
            total_cnt++;
            if (bus.gnt !== exp_gnt) $display("FAIL en_pre k=%0d gnt=%b want %b", k, bus.gnt, exp_gnt);
            else pass_cnt++;
        end
        bus.en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            total_cnt++;
            if (bus.gnt !== 6'b001000 || bus.busy !== 1'b1) $display("FAIL en_finish k=%0d gnt=%b busy=%b want 001000 1", k, bus.gnt, bus.busy);
            else pass_cnt++;
        end
        for (int k = 0; k < 3; k++) begin
            step();
            total_cnt++;
            if (bus.gnt !== 6'd0 || bus.busy !== 1'b0) $display("FAIL en_blocked k=%0d gnt=%b busy=%b want 0 0", k, bus.gnt, bus.busy);
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.y_valid !== 1'b0 || bus.y !== 1'b1) $display("FAIL en_yhold y=%b y_valid=%b want 1 0", bus.y, bus.y_valid);
        else pass_cnt++;
        bus.en = 1'b1;
        step();
        total_cnt++;
        if (bus.gnt !== 6'b010000 || bus.sel !== 3'd4) $display("FAIL en_resume gnt=%b sel=%0d want 010000 4", bus.gnt, bus.sel);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.en  = 1'b1;
        bus.din = 6'b100100;
        bus.req = 6'b100000;
        step();
        step();
        total_cnt++;
        if (bus.gnt !== 6'b100000 || bus.sel !== 3'd5 || bus.y !== 1'b1)
            $display("FAIL mrst_pre gnt=%b sel=%0d y=%b want 100000 5 1", bus.gnt, bus.sel, bus.y);
        else pass_cnt++;
        rst     = 1'b1;
        bus.req = 6'h3F;
        step();
        total_cnt++;
        if (bus.gnt !== 6'd0 || bus.sel !== 3'd0 || bus.busy !== 1'b0 || bus.y !== 1'b0 || bus.y_valid !== 1'b0)
            $display("FAIL mrst_zero gnt=%b sel=%0d busy=%b y=%b y_valid=%b want all 0", bus.gnt, bus.sel, bus.busy, bus.y, bus.y_valid);
        else pass_cnt++;
        rst = 1'b0;
        step();
        total_cnt++;
        if (bus.gnt !== 6'b000001 || bus.sel !== 3'd0) $display("FAIL mrst_regrant gnt=%b sel=%0d want 000001 0", bus.gnt, bus.sel);
        else pass_cnt++;
        // Reset while requester 2 owns the mux must also return ptr to 0
        bus.req = 6'b000100;
        step();
        step();
        rst     = 1'b1;
        bus.req = 6'h3F;
        step();
        rst = 1'b0;
        step();
        total_cnt++;
        if (bus.gnt !== 6'b000001 || bus.sel !== 3'd0) $display("FAIL mrst_ptr gnt=%b sel=%0d want 000001 0", bus.gnt, bus.sel);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        bus.en    = 1'b0;
        bus.req   = 6'd0;
        bus.din   = 6'd0;
        test_reset();
        test_lone_requester();
        test_rotation();
        test_early_release();
        test_en_gate();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
